id_ex_hazard_stage: RTL and testbench
=====================================

Name: id_ex_hazard_stage

Overview:
ID/EX pipeline register combined with load-use hazard detection.
- Captures decoded fields and operands from ID, and drives the EX-stage register addresses and controls that the forwarding logic compares against EX/MEM and MEM/WB.
- Inserts a one-cycle bubble on a load-use dependency, because forwarding alone cannot resolve it.
- Honours a branch flush and an external memory hold.

Parameters:
DATA_W, 32, operand/immediate width
REG_AW, 5, register address width
ALUOP_W, 4, ALU operation code width

Ports:
clk  in  1  pipeline clock, rising edge
rst_n  in  1  asynchronous active-low reset
rs_IF_ID  in  REG_AW  source reg A of instruction in ID
rt_IF_ID  in  REG_AW  source reg B of instruction in ID
rd_IF_ID  in  REG_AW  destination reg of instruction in ID
uses_rt_IF_ID  in  1  instruction in ID reads rt (0 for I-type ALU/LW)
valid_IF_ID  in  1  ID slot holds a real instruction
RegWrite_ID  in  1  decoded register-write control
MemRead_ID  in  1  decoded load control
store_ID  in  1  decoded store control
MemToReg_ID  in  1  decoded writeback select
ALUSrc_ID  in  1  decoded immediate select
ALUOp_ID  in  ALUOP_W  decoded ALU op
rs_data_ID  in  DATA_W  register-file read A
rt_data_ID  in  DATA_W  register-file read B
imm_ID  in  DATA_W  sign-extended immediate
flush  in  1  branch taken: kill instruction in ID
hold  in  1  memory wait: freeze the whole stage
rs_ID_EX, rt_ID_EX, rd_ID_EX  out  REG_AW  registered addresses
RegWrite_ID_EX, MemRead_ID_EX, store_ID_EX, MemToReg_ID_EX, ALUSrc_ID_EX  out  1  registered controls
ALUOp_ID_EX  out  ALUOP_W  registered ALU op
rs_data_ID_EX, rt_data_ID_EX, imm_ID_EX  out  DATA_W  registered operands
valid_ID_EX  out  1  EX slot holds a real instruction
stall  out  1  load-use bubble being inserted this cycle
pc_write  out  1  PC may advance
if_id_write  out  1  IF/ID may load

Behaviour:
- Reset (rst_n low, asynchronous): every registered output is 0. Combinational outputs are then pc_write=1, if_id_write=1, stall=0.
- load_use (combinational) is 1 when all of the following hold:
  - MemRead_ID_EX and valid_ID_EX are 1;
  - rt_ID_EX != 0;
  - valid_IF_ID is 1;
  - rt_ID_EX == rs_IF_ID, or (uses_rt_IF_ID and rt_ID_EX == rt_IF_ID).
- stall = load_use & !hold & !flush.
- pc_write = if_id_write = !(stall | hold).
- Update priority at each rising edge, highest first:
  1. flush: bubble.
  2. hold: all registers keep their value.
  3. stall: bubble.
  4. Otherwise: normal load.
- Bubble: valid_ID_EX, RegWrite_ID_EX, MemRead_ID_EX and store_ID_EX are cleared. Address, data and other fields may load or hold (don't-care).
- Normal load: every field captures its ID input. valid_ID_EX = valid_IF_ID.
- RegWrite_ID_EX is loaded as RegWrite_ID & valid_IF_ID & (rd_IF_ID != 0). This prevents forwarding of $0.
- MemRead_ID_EX and store_ID_EX are gated the same way by valid_IF_ID.
- Latency: 1 cycle ID to EX.
- A stall lasts exactly 1 cycle per dependency. After the bubble, MemRead_ID_EX=0, so load_use deasserts.
- Back-to-back loads re-evaluate each cycle.
- hold asserted during a pending load_use: no stall is reported. The bubble is inserted on the first non-hold edge.
- Reset asserted mid-stall: stall clears immediately. Outputs go to their reset values.

Optional Feature:
HAZARD_STATS_EN
- When defined, adds two outputs:
  - stall_count [31:0]: incremented at each edge where stall=1.
  - flush_count [31:0]: incremented at each edge where flush=1.
- Both counters saturate at 0xFFFFFFFF and reset to 0.
- When undefined, the ports and counters are absent. Behaviour is otherwise identical.

Test Plan:
1. Reset: rst_n=0 mid-cycle -> all registered outputs 0 asynchronously; pc_write=1, stall=0.
2. Load-use: LW reg1,2(reg2) in EX (MemRead_ID_EX=1, rt_ID_EX=1), then LW reg4,4(reg1) in ID (rs_IF_ID=1) -> stall=1 for one cycle, pc_write=0; next edge valid_ID_EX=0, RegWrite_ID_EX=0; the following edge loads rs_ID_EX=1, rt_ID_EX=4.
3. No false hazard: LW reg4 in EX, ORI reg9,reg10,22 in ID (uses_rt_IF_ID=0, rt_IF_ID=4) -> stall=0, normal load.
4. $0 target: LW with rt=0 in EX; ID reads rs=0 -> stall=0. Instruction with RegWrite_ID=1, rd_IF_ID=0 -> RegWrite_ID_EX=0.
5. Priority: flush=1 with load_use=1 and hold=1 -> stall=0, next edge valid_ID_EX=0. hold=1 alone for 3 cycles -> all outputs unchanged, pc_write=0.
6. Data path: SUB reg6,reg3,reg5 with rs_data=0x0000_0010, rt_data=0xFFFF_FFF0 -> captured in rs_data_ID_EX and rt_data_ID_EX one edge later, ALUOp_ID_EX matches ALUOp_ID.

Source files
------------

// File: rtl/id_ex_hazard_stage.sv
// ID/EX pipeline register with load-use hazard detection.
// A load in EX whose destination is read by the instruction in ID cannot be
// covered by forwarding, so a one-cycle bubble is inserted into EX while the
// PC and IF/ID are frozen. Branch flush and memory hold are honoured with
// priority flush > hold > stall > normal load.
// Optional feature macro: HAZARD_STATS_EN adds saturating stall/flush counters.
module id_ex_hazard_stage #(
  parameter int DATA_W  = 32,
  parameter int REG_AW  = 5,
  parameter int ALUOP_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [REG_AW-1:0]  rs_IF_ID,
  input  logic [REG_AW-1:0]  rt_IF_ID,
  input  logic [REG_AW-1:0]  rd_IF_ID,
  input  logic               uses_rt_IF_ID,
  input  logic               valid_IF_ID,
  input  logic               RegWrite_ID,
  input  logic               MemRead_ID,
  input  logic               store_ID,
  input  logic               MemToReg_ID,
  input  logic               ALUSrc_ID,
  input  logic [ALUOP_W-1:0] ALUOp_ID,
  input  logic [DATA_W-1:0]  rs_data_ID,
  input  logic [DATA_W-1:0]  rt_data_ID,
  input  logic [DATA_W-1:0]  imm_ID,
  input  logic               flush,
  input  logic               hold,
  output logic [REG_AW-1:0]  rs_ID_EX,
  output logic [REG_AW-1:0]  rt_ID_EX,
  output logic [REG_AW-1:0]  rd_ID_EX,
  output logic               RegWrite_ID_EX,
  output logic               MemRead_ID_EX,
  output logic               store_ID_EX,
  output logic               MemToReg_ID_EX,
  output logic               ALUSrc_ID_EX,
  output logic [ALUOP_W-1:0] ALUOp_ID_EX,
  output logic [DATA_W-1:0]  rs_data_ID_EX,
  output logic [DATA_W-1:0]  rt_data_ID_EX,
  output logic [DATA_W-1:0]  imm_ID_EX,
  output logic               valid_ID_EX,
`ifdef HAZARD_STATS_EN
  output logic [31:0]        stall_count,
  output logic [31:0]        flush_count,
`endif
  output logic               stall,
  output logic               pc_write,
  output logic               if_id_write
);

  logic [REG_AW-1:0]  rs_q, rs_d;
  logic [REG_AW-1:0]  rt_q, rt_d;
  logic [REG_AW-1:0]  rd_q, rd_d;
  logic               regwrite_q, regwrite_d;
  logic               memread_q, memread_d;
  logic               store_q, store_d;
  logic               memtoreg_q, memtoreg_d;
  logic               alusrc_q, alusrc_d;
  logic [ALUOP_W-1:0] aluop_q, aluop_d;
  logic [DATA_W-1:0]  rs_data_q, rs_data_d;
  logic [DATA_W-1:0]  rt_data_q, rt_data_d;
  logic [DATA_W-1:0]  imm_q, imm_d;
  logic               valid_q, valid_d;
  logic               load_use;

  // Hazard detection: a valid load in EX targeting a non-zero register read by ID.
  always_comb begin
    load_use    = memread_q && valid_q && (rt_q != '0) && valid_IF_ID &&
                  ((rt_q == rs_IF_ID) || (uses_rt_IF_ID && (rt_q == rt_IF_ID)));
    stall       = load_use && !hold && !flush;
    pc_write    = !(stall || hold);
    if_id_write = !(stall || hold);
  end

  // Next-state selection: flush bubble, hold, stall bubble, or normal load.
  always_comb begin
    rs_d       = rs_q;
    rt_d       = rt_q;
    rd_d       = rd_q;
    regwrite_d = regwrite_q;
    memread_d  = memread_q;
    store_d    = store_q;
    memtoreg_d = memtoreg_q;
    alusrc_d   = alusrc_q;
    aluop_d    = aluop_q;
    rs_data_d  = rs_data_q;
    rt_data_d  = rt_data_q;
    imm_d      = imm_q;
    valid_d    = valid_q;
    if (flush || (!hold && stall)) begin
      // Bubble: only the state-changing controls matter; the rest hold.
      valid_d    = 1'b0;
      regwrite_d = 1'b0;
      memread_d  = 1'b0;
      store_d    = 1'b0;
    end else if (!hold) begin
      rs_d       = rs_IF_ID;
      rt_d       = rt_IF_ID;
      rd_d       = rd_IF_ID;
      // Writes to $0 are dropped here so forwarding never matches register 0.
      regwrite_d = RegWrite_ID && valid_IF_ID && (rd_IF_ID != '0);
      memread_d  = MemRead_ID && valid_IF_ID;
      store_d    = store_ID && valid_IF_ID;
      memtoreg_d = MemToReg_ID;
      alusrc_d   = ALUSrc_ID;
      aluop_d    = ALUOp_ID;
      rs_data_d  = rs_data_ID;
      rt_data_d  = rt_data_ID;
      imm_d      = imm_ID;
      valid_d    = valid_IF_ID;
    end
  end

  // ID/EX register bank, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rs_q       <= '0;
      rt_q       <= '0;
      rd_q       <= '0;
      regwrite_q <= 1'b0;
      memread_q  <= 1'b0;
      store_q    <= 1'b0;
      memtoreg_q <= 1'b0;
      alusrc_q   <= 1'b0;
      aluop_q    <= '0;
      rs_data_q  <= '0;
      rt_data_q  <= '0;
      imm_q      <= '0;
      valid_q    <= 1'b0;
    end else begin
      rs_q       <= rs_d;
      rt_q       <= rt_d;
      rd_q       <= rd_d;
      regwrite_q <= regwrite_d;
      memread_q  <= memread_d;
      store_q    <= store_d;
      memtoreg_q <= memtoreg_d;
      alusrc_q   <= alusrc_d;
      aluop_q    <= aluop_d;
      rs_data_q  <= rs_data_d;
      rt_data_q  <= rt_data_d;
      imm_q      <= imm_d;
      valid_q    <= valid_d;
    end
  end

  assign rs_ID_EX       = rs_q;
  assign rt_ID_EX       = rt_q;
  assign rd_ID_EX       = rd_q;
  assign RegWrite_ID_EX = regwrite_q;
  assign MemRead_ID_EX  = memread_q;
  assign store_ID_EX    = store_q;
  assign MemToReg_ID_EX = memtoreg_q;
  assign ALUSrc_ID_EX   = alusrc_q;
  assign ALUOp_ID_EX    = aluop_q;
  assign rs_data_ID_EX  = rs_data_q;
  assign rt_data_ID_EX  = rt_data_q;
  assign imm_ID_EX      = imm_q;
  assign valid_ID_EX    = valid_q;

`ifdef HAZARD_STATS_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  // Saturating event counters for stalls and flushes.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) stall_cnt_d = stall_cnt_q + 32'd1;
    if (flush && (flush_cnt_q != 32'hFFFF_FFFF)) flush_cnt_d = flush_cnt_q + 32'd1;
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_count = stall_cnt_q;
  assign flush_count = flush_cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_hazard_stage.sv
// Directed testbench for id_ex_hazard_stage (default build).
module tb_id_ex_hazard_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  rs_IF_ID, rt_IF_ID, rd_IF_ID;
  logic        uses_rt_IF_ID, valid_IF_ID;
  logic        RegWrite_ID, MemRead_ID, store_ID, MemToReg_ID, ALUSrc_ID;
  logic [3:0]  ALUOp_ID;
  logic [31:0] rs_data_ID, rt_data_ID, imm_ID;
  logic        flush, hold;
  logic [4:0]  rs_ID_EX, rt_ID_EX, rd_ID_EX;
  logic        RegWrite_ID_EX, MemRead_ID_EX, store_ID_EX, MemToReg_ID_EX, ALUSrc_ID_EX;
  logic [3:0]  ALUOp_ID_EX;
  logic [31:0] rs_data_ID_EX, rt_data_ID_EX, imm_ID_EX;
  logic        valid_ID_EX, stall, pc_write, if_id_write;
  logic [120:0] regs_all;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  assign regs_all = {rs_ID_EX, rt_ID_EX, rd_ID_EX, RegWrite_ID_EX, MemRead_ID_EX,
                     store_ID_EX, MemToReg_ID_EX, ALUSrc_ID_EX, ALUOp_ID_EX,
                     rs_data_ID_EX, rt_data_ID_EX, imm_ID_EX, valid_ID_EX};

  id_ex_hazard_stage dut (
    .clk(clk), .rst_n(rst_n),
    .rs_IF_ID(rs_IF_ID), .rt_IF_ID(rt_IF_ID), .rd_IF_ID(rd_IF_ID),
    .uses_rt_IF_ID(uses_rt_IF_ID), .valid_IF_ID(valid_IF_ID),
    .RegWrite_ID(RegWrite_ID), .MemRead_ID(MemRead_ID), .store_ID(store_ID),
    .MemToReg_ID(MemToReg_ID), .ALUSrc_ID(ALUSrc_ID), .ALUOp_ID(ALUOp_ID),
    .rs_data_ID(rs_data_ID), .rt_data_ID(rt_data_ID), .imm_ID(imm_ID),
    .flush(flush), .hold(hold),
    .rs_ID_EX(rs_ID_EX), .rt_ID_EX(rt_ID_EX), .rd_ID_EX(rd_ID_EX),
    .RegWrite_ID_EX(RegWrite_ID_EX), .MemRead_ID_EX(MemRead_ID_EX),
    .store_ID_EX(store_ID_EX), .MemToReg_ID_EX(MemToReg_ID_EX),
    .ALUSrc_ID_EX(ALUSrc_ID_EX), .ALUOp_ID_EX(ALUOp_ID_EX),
    .rs_data_ID_EX(rs_data_ID_EX), .rt_data_ID_EX(rt_data_ID_EX),
    .imm_ID_EX(imm_ID_EX), .valid_ID_EX(valid_ID_EX),
    .stall(stall), .pc_write(pc_write), .if_id_write(if_id_write)
  );

  // Drive the instruction currently sitting in ID.
  task automatic set_id(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                        input logic uses_rt, input logic valid, input logic regw,
                        input logic memr, input logic st, input logic m2r, input logic asrc,
                        input logic [3:0] op, input logic [31:0] rsd,
                        input logic [31:0] rtd, input logic [31:0] imm);
    rs_IF_ID = rs; rt_IF_ID = rt; rd_IF_ID = rd; uses_rt_IF_ID = uses_rt;
    valid_IF_ID = valid; RegWrite_ID = regw; MemRead_ID = memr; store_ID = st;
    MemToReg_ID = m2r; ALUSrc_ID = asrc; ALUOp_ID = op;
    rs_data_ID = rsd; rt_data_ID = rtd; imm_ID = imm;
  endtask

  // Advance one clock; return 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // A NOP-like idle ID slot.
  task automatic idle_id();
    set_id(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0, 32'd0);
  endtask

  // LW rt <- imm(rs)
  task automatic lw(input logic [4:0] base, input logic [4:0] dst, input logic [31:0] off);
    set_id(base, dst, dst, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 4'd2, 32'h100, 32'd0, off);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; hold = 1'b0;
    idle_id();
    tick(); tick();
    n_checks++; if (regs_all !== '0) begin n_fail++; $display("FAIL reset_regs actual=%h required=0", regs_all); end
    n_checks++; if (pc_write !== 1'b1 || if_id_write !== 1'b1) begin n_fail++; $display("FAIL reset_pc_write actual=%b/%b required=1/1", pc_write, if_id_write); end
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall actual=%b required=0", stall); end
    rst_n = 1'b1;
    // Build a load-use hazard and then reset asynchronously in the middle of it.
    lw(5'd2, 5'd1, 32'd2);
    tick();
    lw(5'd1, 5'd4, 32'd4);
    #1;
    n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL reset_prestall actual=%b required=1", stall); end
    rst_n = 1'b0;
    #1;
    n_checks++; if (stall !== 1'b0 || pc_write !== 1'b1) begin n_fail++; $display("FAIL reset_midstall stall/pc_write actual=%b/%b required=0/1", stall, pc_write); end
    n_checks++; if (regs_all !== '0) begin n_fail++; $display("FAIL reset_async_regs actual=%h required=0", regs_all); end
    rst_n = 1'b1;
    idle_id();
    tick();
  endtask

  task automatic test_load_use();
    lw(5'd2, 5'd1, 32'd2);               // LW reg1,2(reg2)
    tick();
    n_checks++; if (MemRead_ID_EX !== 1'b1 || rt_ID_EX !== 5'd1 || RegWrite_ID_EX !== 1'b1) begin n_fail++; $display("FAIL lu_load_in_ex memread/rt/regw actual=%b/%0d/%b required=1/1/1", MemRead_ID_EX, rt_ID_EX, RegWrite_ID_EX); end
    lw(5'd1, 5'd4, 32'd4);               // LW reg4,4(reg1)
    #1;
    n_checks++; if (stall !== 1'b1 || pc_write !== 1'b0 || if_id_write !== 1'b0) begin n_fail++; $display("FAIL lu_stall stall/pc/ifid actual=%b/%b/%b required=1/0/0", stall, pc_write, if_id_write); end
    tick();
    n_checks++; if (valid_ID_EX !== 1'b0 || RegWrite_ID_EX !== 1'b0 || MemRead_ID_EX !== 1'b0) begin n_fail++; $display("FAIL lu_bubble valid/regw/memr actual=%b/%b/%b required=0/0/0", valid_ID_EX, RegWrite_ID_EX, MemRead_ID_EX); end
    n_checks++; if (stall !== 1'b0 || pc_write !== 1'b1) begin n_fail++; $display("FAIL lu_stall_one_cycle stall/pc actual=%b/%b required=0/1", stall, pc_write); end
    tick();
    n_checks++; if (rs_ID_EX !== 5'd1 || rt_ID_EX !== 5'd4 || valid_ID_EX !== 1'b1 || MemRead_ID_EX !== 1'b1) begin n_fail++; $display("FAIL lu_reload rs/rt/valid/memr actual=%0d/%0d/%b/%b required=1/4/1/1", rs_ID_EX, rt_ID_EX, valid_ID_EX, MemRead_ID_EX); end
  endtask

  task automatic test_no_false_hazard();
    // EX now holds LW reg4. ORI reg9,reg10,22 has rt field 4 but does not read it.
    set_id(5'd10, 5'd4, 5'd9, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'd3, 32'h55, 32'h66, 32'd22);
    #1;
    n_checks++; if (stall !== 1'b0 || pc_write !== 1'b1) begin n_fail++; $display("FAIL nfh_stall stall/pc actual=%b/%b required=0/1", stall, pc_write); end
    tick();
    n_checks++; if (rs_ID_EX !== 5'd10 || rd_ID_EX !== 5'd9 || imm_ID_EX !== 32'd22 || valid_ID_EX !== 1'b1 || RegWrite_ID_EX !== 1'b1 || MemRead_ID_EX !== 1'b0) begin n_fail++; $display("FAIL nfh_load rs/rd/imm/v/rw/mr actual=%0d/%0d/%0d/%b/%b/%b required=10/9/22/1/1/0", rs_ID_EX, rd_ID_EX, imm_ID_EX, valid_ID_EX, RegWrite_ID_EX, MemRead_ID_EX); end
  endtask

  task automatic test_zero_reg();
    lw(5'd2, 5'd0, 32'd8);               // LW $0 (rd=0)
    tick();
    n_checks++; if (MemRead_ID_EX !== 1'b1 || RegWrite_ID_EX !== 1'b0) begin n_fail++; $display("FAIL zero_lw memr/regw actual=%b/%b required=1/0", MemRead_ID_EX, RegWrite_ID_EX); end
    set_id(5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1, 32'd0, 32'd0, 32'd0);
    #1;
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL zero_stall actual=%b required=0", stall); end
    tick();
    n_checks++; if (RegWrite_ID_EX !== 1'b0 || valid_ID_EX !== 1'b1) begin n_fail++; $display("FAIL zero_regwrite regw/valid actual=%b/%b required=0/1", RegWrite_ID_EX, valid_ID_EX); end
  endtask

  task automatic test_invalid_id();
    lw(5'd2, 5'd3, 32'd0);
    tick();
    // ID slot invalid: no hazard and the controls must not leak into EX.
    set_id(5'd3, 5'd3, 5'd7, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd1, 32'd0, 32'd0, 32'd0);
    #1;
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL inv_stall actual=%b required=0", stall); end
    tick();
    n_checks++; if (valid_ID_EX !== 1'b0 || RegWrite_ID_EX !== 1'b0 || MemRead_ID_EX !== 1'b0 || store_ID_EX !== 1'b0) begin n_fail++; $display("FAIL inv_gate v/rw/mr/st actual=%b/%b/%b/%b required=0/0/0/0", valid_ID_EX, RegWrite_ID_EX, MemRead_ID_EX, store_ID_EX); end
  endtask

  task automatic test_priority();
    lw(5'd2, 5'd7, 32'd0);
    tick();
    set_id(5'd7, 5'd1, 5'd8, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1, 32'd0, 32'd0, 32'd0);
    flush = 1'b1; hold = 1'b1;
    #1;
    n_checks++; if (stall !== 1'b0 || pc_write !== 1'b0) begin n_fail++; $display("FAIL prio_flush_hold stall/pc actual=%b/%b required=0/0", stall, pc_write); end
    tick();
    n_checks++; if (valid_ID_EX !== 1'b0 || MemRead_ID_EX !== 1'b0 || RegWrite_ID_EX !== 1'b0) begin n_fail++; $display("FAIL prio_flush_bubble v/mr/rw actual=%b/%b/%b required=0/0/0", valid_ID_EX, MemRead_ID_EX, RegWrite_ID_EX); end
    flush = 1'b0; hold = 1'b0;
    // ADD reg6,reg3,reg5 loaded, then held for three cycles against changing ID.
    set_id(5'd3, 5'd5, 5'd6, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd2, 32'h11, 32'h22, 32'h0);
    tick();
    hold = 1'b1;
    set_id(5'd12, 5'd13, 5'd14, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 4'd9, 32'hAA, 32'hBB, 32'hCC);
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++; if (rs_ID_EX !== 5'd3 || rd_ID_EX !== 5'd6 || valid_ID_EX !== 1'b1 || RegWrite_ID_EX !== 1'b1 || rs_data_ID_EX !== 32'h11 || ALUOp_ID_EX !== 4'd2) begin n_fail++; $display("FAIL hold_keep cycle %0d rs/rd/v/rw/rsd/op actual=%0d/%0d/%b/%b/%h/%0d required=3/6/1/1/11/2", i, rs_ID_EX, rd_ID_EX, valid_ID_EX, RegWrite_ID_EX, rs_data_ID_EX, ALUOp_ID_EX); end
      n_checks++; if (pc_write !== 1'b0 || if_id_write !== 1'b0 || stall !== 1'b0) begin n_fail++; $display("FAIL hold_ctrl cycle %0d pc/ifid/stall actual=%b/%b/%b required=0/0/0", i, pc_write, if_id_write, stall); end
    end
    hold = 1'b0;
    // Pending load-use under hold: bubble waits for the first non-hold edge.
    lw(5'd2, 5'd8, 32'd0);
    tick();
    set_id(5'd8, 5'd0, 5'd9, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'd1, 32'd0, 32'd0, 32'd5);
    hold = 1'b1;
    #1;
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL hold_pending_stall actual=%b required=0", stall); end
    tick();
    n_checks++; if (MemRead_ID_EX !== 1'b1 || rt_ID_EX !== 5'd8 || valid_ID_EX !== 1'b1) begin n_fail++; $display("FAIL hold_pending_keep mr/rt/v actual=%b/%0d/%b required=1/8/1", MemRead_ID_EX, rt_ID_EX, valid_ID_EX); end
    hold = 1'b0;
    #1;
    n_checks++; if (stall !== 1'b1 || pc_write !== 1'b0) begin n_fail++; $display("FAIL hold_release_stall stall/pc actual=%b/%b required=1/0", stall, pc_write); end
    tick();
    n_checks++; if (valid_ID_EX !== 1'b0 || MemRead_ID_EX !== 1'b0) begin n_fail++; $display("FAIL hold_release_bubble v/mr actual=%b/%b required=0/0", valid_ID_EX, MemRead_ID_EX); end
  endtask

  task automatic test_datapath();
    // SUB reg6,reg3,reg5
    set_id(5'd3, 5'd5, 5'd6, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0110, 32'h0000_0010, 32'hFFFF_FFF0, 32'h0);
    #1;
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL dp_stall actual=%b required=0", stall); end
    tick();
    n_checks++; if (rs_data_ID_EX !== 32'h0000_0010 || rt_data_ID_EX !== 32'hFFFF_FFF0) begin n_fail++; $display("FAIL dp_data rsd/rtd actual=%h/%h required=00000010/fffffff0", rs_data_ID_EX, rt_data_ID_EX); end
    n_checks++; if (ALUOp_ID_EX !== 4'b0110 || rd_ID_EX !== 5'd6 || rt_ID_EX !== 5'd5 || ALUSrc_ID_EX !== 1'b0 || RegWrite_ID_EX !== 1'b1) begin n_fail++; $display("FAIL dp_fields op/rd/rt/asrc/rw actual=%0d/%0d/%0d/%b/%b required=6/6/5/0/1", ALUOp_ID_EX, rd_ID_EX, rt_ID_EX, ALUSrc_ID_EX, RegWrite_ID_EX); end
  endtask

  task automatic test_back_to_back();
    lw(5'd2, 5'd1, 32'd0);               // LW reg1
    tick();
    lw(5'd1, 5'd2, 32'd0);               // LW reg2,0(reg1): hazard on rs
    #1;
    n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL b2b_first_stall actual=%b required=1", stall); end
    tick();
    n_checks++; if (stall !== 1'b0 || valid_ID_EX !== 1'b0) begin n_fail++; $display("FAIL b2b_bubble stall/v actual=%b/%b required=0/0", stall, valid_ID_EX); end
    tick();
    // ADD reg3,reg5,reg2: hazard on rt through uses_rt.
    set_id(5'd5, 5'd2, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd2, 32'd1, 32'd2, 32'd0);
    #1;
    n_checks++; if (stall !== 1'b1 || MemRead_ID_EX !== 1'b1 || rt_ID_EX !== 5'd2) begin n_fail++; $display("FAIL b2b_second_stall stall/mr/rt actual=%b/%b/%0d required=1/1/2", stall, MemRead_ID_EX, rt_ID_EX); end
    tick();
    n_checks++; if (valid_ID_EX !== 1'b0 || stall !== 1'b0) begin n_fail++; $display("FAIL b2b_second_bubble v/stall actual=%b/%b required=0/0", valid_ID_EX, stall); end
    tick();
    n_checks++; if (rd_ID_EX !== 5'd3 || valid_ID_EX !== 1'b1 || RegWrite_ID_EX !== 1'b1) begin n_fail++; $display("FAIL b2b_add_loaded rd/v/rw actual=%0d/%b/%b required=3/1/1", rd_ID_EX, valid_ID_EX, RegWrite_ID_EX); end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_no_false_hazard();
    test_zero_reg();
    test_invalid_id();
    test_priority();
    test_datapath();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
